// File: rtl/gfx_fetch_pkg.sv
// gfx_fetch_pkg: FSM state encoding and FIFO sizing shared by the GFX line fetcher
// Contents: state_t (IDLE, REQ, WAIT, FINISH), default FIFO address width, depth helper.
package gfx_fetch_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, FINISH} state_t;
    localparam int FIFO_AW_DEF = 3;
    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction
endpackage

// File: rtl/gfx_fetch_fifo.sv
// gfx_fetch_fifo: synchronous BITS x 2^AW FIFO holding fetched words for the pixel stream
// Ports: CLK, RST (sync, active-high); PUSH/PUSH_DATA write; POP read (ignored when empty);
// FLUSH empties the FIFO and wins over push/pop; HEAD is the oldest word; LEVEL is occupancy.
module gfx_fetch_fifo
    import gfx_fetch_pkg::*;
#(
    parameter int BITS = 16,
    parameter int AW   = FIFO_AW_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            PUSH,
    input  logic [BITS-1:0] PUSH_DATA,
    input  logic            POP,
    input  logic            FLUSH,
    output logic [BITS-1:0] HEAD,
    output logic [AW:0]     LEVEL
);
    localparam logic [AW:0] DEPTH = (AW+1)'(fifo_depth(AW));
    logic [BITS-1:0] mem [fifo_depth(AW)];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_pop  = POP && LEVEL != '0;
    assign do_push = PUSH && (LEVEL != DEPTH || do_pop);
    assign HEAD    = mem[rd_ptr];
    always_ff @(posedge CLK) begin
        if (do_push && !FLUSH) mem[wr_ptr] <= PUSH_DATA;
    end
    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            LEVEL  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            LEVEL  <= LEVEL + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/gfx_line_fetcher.sv
// gfx_line_fetcher: fetches a line of words over the GFX memory port into a pixel FIFO
// Ports: CLK, RST (sync, active-high); START/BASE_ADDR/WORD_COUNT/ABORT line control;
// BUSY/DONE status; GFX_ADDRESS/GFX_VALID/GFX_READY/GFX_DATA memory fetch port;
// PIX_DATA/PIX_VALID/PIX_READY pixel stream; FIFO_LEVEL occupancy.
// Build option GFX_FETCH_UNDERFLOW_EN adds sticky UNDERFLOW (pop while empty during a line).
module gfx_line_fetcher
    import gfx_fetch_pkg::*;
#(
    parameter int BITS         = 16,
    parameter int ADDRESS_BITS = 15,
    parameter int COUNT_BITS   = 9,
    parameter int FIFO_AW      = FIFO_AW_DEF
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    input  logic [ADDRESS_BITS-1:0] BASE_ADDR,
    input  logic [COUNT_BITS-1:0]   WORD_COUNT,
    input  logic                    ABORT,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [ADDRESS_BITS-1:0] GFX_ADDRESS,
    output logic                    GFX_VALID,
    input  logic                    GFX_READY,
    input  logic [BITS-1:0]         GFX_DATA,
    output logic [BITS-1:0]         PIX_DATA,
    output logic                    PIX_VALID,
    input  logic                    PIX_READY,
    output logic [FIFO_AW:0]        FIFO_LEVEL
`ifdef GFX_FETCH_UNDERFLOW_EN
   ,output logic                    UNDERFLOW
`endif
);
    localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(fifo_depth(FIFO_AW));
    state_t state;
    logic [COUNT_BITS-1:0] remaining;
    logic inflight, aborting, rdy, issue, pop, push, flush, space, end_req;
    logic [FIFO_AW:0] level_n;
    // inflight mirrors the memory's pending READY; a READY without it (e.g. after RST) is ignored
    assign rdy     = inflight & GFX_READY;
    // memory accepts VALID only outside its READY cycle
    assign issue   = GFX_VALID & ~inflight;
    assign pop     = PIX_READY & PIX_VALID;
    assign flush   = ABORT | aborting;
    assign push    = rdy & ~flush;
    assign level_n = flush ? '0 : FIFO_LEVEL + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    // a new request reserves its FIFO slot at issue, so only issue into a non-full FIFO
    assign space   = level_n < DEPTH;
    assign end_req = aborting | (ABORT & ~issue) | (rdy & remaining == COUNT_BITS'(1));
    assign PIX_VALID = FIFO_LEVEL != '0;
    gfx_fetch_fifo #(.BITS(BITS), .AW(FIFO_AW)) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .PUSH      (push),
        .PUSH_DATA (GFX_DATA),
        .POP       (PIX_READY),
        .FLUSH     (flush),
        .HEAD      (PIX_DATA),
        .LEVEL     (FIFO_LEVEL)
    );
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            remaining   <= '0;
            inflight    <= 1'b0;
            aborting    <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            GFX_VALID   <= 1'b0;
            GFX_ADDRESS <= '0;
        end else begin
            inflight <= issue;
            DONE     <= 1'b0;
            if (rdy) begin
                GFX_ADDRESS <= GFX_ADDRESS + ADDRESS_BITS'(1);
                remaining   <= remaining - COUNT_BITS'(1);
            end
            case (state)
                IDLE: if (START) begin
                    GFX_ADDRESS <= BASE_ADDR;
                    remaining   <= WORD_COUNT;
                    if (WORD_COUNT == '0) begin
                        state <= FINISH;
                        DONE  <= 1'b1;
                    end else begin
                        state     <= space ? REQ : WAIT;
                        GFX_VALID <= space;
                        BUSY      <= 1'b1;
                    end
                end
                // VALID stays high through the READY cycle so the address is stable for the memory
                REQ: if (end_req) begin
                    state     <= FINISH;
                    DONE      <= 1'b1;
                    BUSY      <= 1'b0;
                    GFX_VALID <= 1'b0;
                    aborting  <= 1'b0;
                end else if (ABORT) begin
                    aborting  <= 1'b1;
                    GFX_VALID <= 1'b0;
                end else if (!issue) begin
                    state     <= space ? REQ : WAIT;
                    GFX_VALID <= space;
                end
                WAIT: if (ABORT) begin
                    state <= FINISH;
                    DONE  <= 1'b1;
                    BUSY  <= 1'b0;
                end else if (space) begin
                    state     <= REQ;
                    GFX_VALID <= 1'b1;
                end
                FINISH: state <= IDLE;
            endcase
        end
    end
`ifdef GFX_FETCH_UNDERFLOW_EN
    always_ff @(posedge CLK) begin
        if (RST || (START && state == IDLE)) UNDERFLOW <= 1'b0;
        else if (PIX_READY && !PIX_VALID && BUSY) UNDERFLOW <= 1'b1;
    end
`endif
endmodule
